// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC rotation engine:
//   - state_e     : FSM state encoding (GAIN exists only with CORDIC_GAIN_COMP_EN)
//   - frac_bits() : fractional bit count of the Q2.(BIT_WIDTH-2) datapath
//   - K_Q62       : CORDIC gain-compensation constant K = 0.6072529350 in Q2.62
// Configuration macro: CORDIC_GAIN_COMP_EN (adds the GAIN state).
// -----------------------------------------------------------------------------
package cordic_pkg;

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAIN,
    ST_DONE
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;
`endif

  // Two integer bits (sign + one), the rest fraction.
  function automatic int frac_bits(input int bit_width);
    return bit_width - 2;
  endfunction

  // K in Q2.62; the engine rescales it to its own width by keeping the top
  // BIT_WIDTH bits, which truncates toward -inf (K is positive).
  localparam logic [63:0] K_Q62 = 64'd2800459869988495389;

endpackage

// File: rtl/cordic_rotation_engine.sv
// -----------------------------------------------------------------------------
// cordic_rotation_engine
// Iterative rotation-mode CORDIC: rotates (x_in, y_in) by angle z_in, one
// micro-rotation per clock. The arctangent table lives outside this block:
// count_out selects the entry and atan_in returns it combinationally.
//
// Parameters:
//   BIT_WIDTH  - signed datapath width, fixed point Q2.(BIT_WIDTH-2)
//   ITERATIONS - number of micro-rotations (1..63)
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   start                   - request a rotation (sampled only in IDLE)
//   x_in, y_in, z_in        - start vector and angle in radians
//   count_out               - iteration index to the arctangent table
//   atan_in                 - atan(2^-count_out) from the table
//   busy                    - operation in flight (through the done cycle)
//   done                    - one-cycle pulse, results valid
//   x_out, y_out, z_out     - results, held until the next completion
// Configuration macro: CORDIC_GAIN_COMP_EN
//   defined   : extra GAIN cycle scales x/y by K (~0.60725)
//   undefined : x_out/y_out carry the raw CORDIC gain (~1.6468)
// -----------------------------------------------------------------------------
module cordic_rotation_engine
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH  = 64,
  parameter int ITERATIONS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [BIT_WIDTH-1:0] x_in,
  input  logic signed [BIT_WIDTH-1:0] y_in,
  input  logic signed [BIT_WIDTH-1:0] z_in,
  output logic        [5:0]           count_out,
  input  logic signed [BIT_WIDTH-1:0] atan_in,
  output logic                        busy,
  output logic                        done,
  output logic signed [BIT_WIDTH-1:0] x_out,
  output logic signed [BIT_WIDTH-1:0] y_out,
  output logic signed [BIT_WIDTH-1:0] z_out
);

  localparam logic [5:0] LAST_COUNT = 6'(ITERATIONS - 1);

  state_e                      state_q, state_d;
  logic        [5:0]           count_q, count_d;
  logic        [5:0]           count_out_q, count_out_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic signed [BIT_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [BIT_WIDTH-1:0] x_out_q, x_out_d;
  logic signed [BIT_WIDTH-1:0] y_out_q, y_out_d;
  logic signed [BIT_WIDTH-1:0] z_out_q, z_out_d;

  // One micro-rotation. A negative angle residue (sign bit set) means d = -1.
  logic                        z_neg;
  logic signed [BIT_WIDTH-1:0] x_sh, y_sh, x_rot, y_rot, z_rot;

  assign z_neg = z_q[BIT_WIDTH-1];
  assign x_sh  = x_q >>> count_q;
  assign y_sh  = y_q >>> count_q;
  assign x_rot = z_neg ? x_q + y_sh : x_q - y_sh;
  assign y_rot = z_neg ? y_q - x_sh : y_q + x_sh;
  assign z_rot = z_neg ? z_q + atan_in : z_q - atan_in;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int FRAC_BITS = frac_bits(BIT_WIDTH);
  localparam logic [BIT_WIDTH+63:0] K_WIDE = {K_Q62, {BIT_WIDTH{1'b0}}};
  localparam logic signed [BIT_WIDTH-1:0] K_FIX = K_WIDE[BIT_WIDTH+63 -: BIT_WIDTH];

  // Full-precision product, then arithmetic shift: truncation toward -inf.
  logic signed [2*BIT_WIDTH-1:0] x_prod, y_prod;
  logic signed [BIT_WIDTH-1:0]   x_gain, y_gain;

  assign x_prod = x_q * K_FIX;
  assign y_prod = y_q * K_FIX;
  assign x_gain = BIT_WIDTH'(x_prod >>> FRAC_BITS);
  assign y_gain = BIT_WIDTH'(y_prod >>> FRAC_BITS);
`endif

  always_comb begin
    // NOTE: every _d gets a hold value first so no path through the case
    // leaves a variable unassigned, which would infer a latch.
    state_d = state_q;
    count_d = count_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_out_d = z_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        x_d     = x_rot;
        y_d     = y_rot;
        z_d     = z_rot;
        count_d = count_q + 6'd1;
        if (count_q == LAST_COUNT) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = ST_GAIN;
`else
          state_d = ST_DONE;
          x_out_d = x_rot;
          y_out_d = y_rot;
          z_out_d = z_rot;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      ST_GAIN: begin
        state_d = ST_DONE;
        x_out_d = x_gain;
        y_out_d = y_gain;
        z_out_d = z_q;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered, so derive them from the next state.
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    count_out_d = (state_d == ST_RUN) ? count_d : 6'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      count_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      count_out_q <= count_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      z_out_q     <= z_out_d;
    end
  end

  assign count_out = count_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;

endmodule

// File: tb/tb_cordic_rotation_engine.sv
// -----------------------------------------------------------------------------
// tb_cordic_rotation_engine
// Bench for cordic_rotation_engine at BIT_WIDTH=16, ITERATIONS=8 (1.0 = 16384).
// Provides the arctangent table, a plain-arithmetic rotation model, spec
// vectors with tolerances, random vectors, and hand-written corner sequences.
// Follows CORDIC_GAIN_COMP_EN to pick the expected gain and latency.
// -----------------------------------------------------------------------------
module tb_cordic_rotation_engine;

  localparam int W = 16;
  localparam int N = 8;
`ifdef CORDIC_GAIN_COMP_EN
  localparam bit GAIN_EN = 1'b1;
`else
  localparam bit GAIN_EN = 1'b0;
`endif
  localparam int     LAT         = GAIN_EN ? N + 2 : N + 1;
  localparam longint K_Q14       = 9949;    // floor(0.6072529350 * 16384)
  localparam real    CORDIC_GAIN = 1.6468;
  // round(atan(2^-i) * 16384)
  localparam int ATAN_TAB [8] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128};

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [W-1:0] x_in, y_in, z_in;
  logic        [5:0]   count_out;
  logic signed [W-1:0] atan_in;
  logic                busy, done;
  logic signed [W-1:0] x_out, y_out, z_out;

  always #5 clk = ~clk;

  assign atan_in = (count_out < 6'd8) ? W'(ATAN_TAB[count_out[2:0]]) : '0;

  cordic_rotation_engine #(.BIT_WIDTH(W), .ITERATIONS(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .count_out(count_out), .atan_in(atan_in),
    .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic signed [63:0] got,
                           input longint exp, input longint tol);
    longint diff;
    checks++;
    diff = longint'(got) - exp;
    if ($isunknown(got) || diff > tol || diff < -tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, got, exp, tol);
    end
  endtask

  function automatic int wrap16(input longint v);
    logic signed [15:0] s;
    s = v[15:0];
    return int'(s);
  endfunction

  // Rotation by the rules: d from the sign of the residual angle, shift-add
  // pseudo-rotations, everything modulo 2^16, optional K scaling at the end.
  function automatic void model(input int xi, input int yi, input int zi,
                                output int xo, output int yo, output int zo);
    int x, y, z, xn, yn, zn, d;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < N; i++) begin
      d  = (z >= 0) ? 1 : -1;
      xn = wrap16(x - d * (y >>> i));
      yn = wrap16(y + d * (x >>> i));
      zn = wrap16(z - d * ATAN_TAB[i]);
      x = xn; y = yn; z = zn;
    end
    if (GAIN_EN) begin
      x = wrap16((longint'(x) * K_Q14) >>> 14);
      y = wrap16((longint'(y) * K_Q14) >>> 14);
    end
    xo = x; yo = y; zo = z;
  endfunction

  int lat;
  int cnt_seen[$];

  // One complete operation with latency, busy, count_out capture and exact
  // comparison against the model.
  task automatic do_op(input int xi, input int yi, input int zi, input string tag);
    int xe, ye, ze;
    model(xi, yi, zi, xe, ye, ze);
    cnt_seen.delete();
    @(negedge clk);
    x_in = W'(xi); y_in = W'(yi); z_in = W'(zi); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check($sformatf("%s busy_first", tag), busy, 1);
    cnt_seen.push_back(count_out);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      cnt_seen.push_back(count_out);
    end
    check($sformatf("%s latency", tag), lat, LAT);
    check($sformatf("%s busy_at_done", tag), busy, 1);
    check($sformatf("%s x_out", tag), x_out, xe);
    check($sformatf("%s y_out", tag), y_out, ye);
    check($sformatf("%s z_out", tag), z_out, ze);
    @(negedge clk);
    check($sformatf("%s done_single", tag), done, 0);
    check($sformatf("%s busy_after", tag), busy, 0);
  endtask

  typedef struct {
    int x, y, z;       // stimulus
    int ex, ey;        // ideal rotated vector (unit gain)
    int tol_off;       // x/y tolerance, raw gain
    int tol_on;        // x/y tolerance, compensated
    int ztol;          // residual angle bound
  } vec_t;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab [5];
    int xa, ya, za, xb, yb, zb, xd, yd, zd, xr, yr, zr;
    int ex, ey, tol, ndone, t, g;

    tab[0] = '{16384, 0,  12868, 11585,  11585, 200, 128, 128};
    tab[1] = '{16384, 0, -12868, 11585, -11585, 200, 128, 128};
    tab[2] = '{16384, 0,      0, 16384,      0, 350, 220, 160};
    tab[3] = '{16384, 0,   8192, 14378,   7855, 350, 220, 160};
    tab[4] = '{0,  8192,  -8192,  3928,   7189, 350, 220, 160};

    rst = 1'b1; start = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    repeat (2) @(negedge clk);
    check("reset x_out", x_out, 0);
    check("reset y_out", y_out, 0);
    check("reset z_out", z_out, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset count_out", count_out, 0);
    rst = 1'b0;

    // Spec and geometric vectors: exact vs model, plus tolerance vs ideal.
    for (int i = 0; i < 5; i++) begin
      do_op(tab[i].x, tab[i].y, tab[i].z, $sformatf("vec%0d", i));
      if (i == 0) begin
        check("count_seq len", cnt_seen.size(), LAT);
        for (int k = 0; k < cnt_seen.size() && k < LAT; k++)
          check($sformatf("count_seq[%0d]", k), cnt_seen[k], (k < N) ? k : 0);
      end
      ex  = GAIN_EN ? tab[i].ex : int'(real'(tab[i].ex) * CORDIC_GAIN);
      ey  = GAIN_EN ? tab[i].ey : int'(real'(tab[i].ey) * CORDIC_GAIN);
      tol = GAIN_EN ? tab[i].tol_on : tab[i].tol_off;
      check_tol($sformatf("vec%0d x_ideal", i), x_out, ex, tol);
      check_tol($sformatf("vec%0d y_ideal", i), y_out, ey, tol);
      check_tol($sformatf("vec%0d z_resid", i), z_out, 0, tab[i].ztol);
    end

    // Random vectors over the full 16-bit range (wrap behaviour included).
    for (int i = 0; i < 20; i++)
      do_op(wrap16(longint'($urandom)), wrap16(longint'($urandom)),
            wrap16(longint'($urandom)), $sformatf("rand%0d", i));

    // Hold between operations, starts during busy and DONE are ignored.
    model(12000, -3000, 5000, xa, ya, za);
    do_op(12000, -3000, 5000, "opA");
    repeat (3) @(negedge clk);
    check("hold_idle x_out", x_out, xa);
    model(-7000, 9000, -15000, xb, yb, zb);
    @(negedge clk);
    x_in = -16'sd7000; y_in = 16'sd9000; z_in = -16'sd15000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("hold_run x_out", x_out, xa);
    check("hold_run y_out", y_out, ya);
    x_in = 16'sd100; y_in = 16'sd200; z_in = 16'sd300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("busy_start x_out", x_out, xb);
          check("busy_start y_out", y_out, yb);
          check("busy_start z_out", z_out, zb);
        end
        start = 1'b1;   // start during DONE
      end else begin
        start = 1'b0;
      end
    end
    check("busy_start done_count", ndone, 1);

    // Start held high: back-to-back operations, one idle cycle between.
    model(5000, 5000, 3000, xd, yd, zd);
    @(negedge clk);
    x_in = 16'sd5000; y_in = 16'sd5000; z_in = 16'sd3000; start = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 40);
    check("held_start first_latency", t, LAT);
    g = 0;
    do begin @(negedge clk); g++; end while (!done && g < 40);
    start = 1'b0;
    check("held_start gap", g, LAT + 1);
    check("held_start x_out", x_out, xd);
    check("held_start y_out", y_out, yd);
    @(negedge clk);
    check("held_start idle_after", busy, 0);

    // Reset in the middle of RUN aborts at once, no done, then recovers.
    @(negedge clk);
    x_in = 16'sd16384; y_in = 16'sd0; z_in = 16'sd12868; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (count_out != 6'd4 && t < 20) begin @(negedge clk); t++; end
    check("abort reached_count4", count_out, 4);
    rst = 1'b1;
    #1;
    check("abort x_out", x_out, 0);
    check("abort y_out", y_out, 0);
    check("abort z_out", z_out, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort count_out", count_out, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no_done", ndone, 0);
    model(-16384, 4000, 10000, xr, yr, zr);
    do_op(-16384, 4000, 10000, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
